// File: rtl/dpram_be_pipe.sv
// Simple dual-port RAM: byte-enable write port A, pipelined read port B, zero-fill clear engine.
// Latency: read_latency clocks from accepted rden_b to q_valid_b; one read per clock, in order.
// Backpressure: none; reads and writes presented while busy are dropped, q_b holds between beats.
module dpram_be_pipe #(
    parameter int numwords       = 256,
    parameter int widthad        = 8,
    parameter int width          = 32,
    parameter int read_latency   = 1,
    parameter int bypass         = 1,
    parameter int clear_on_reset = 0
) (
    input  logic                 clock_in,
    input  logic                 reset_in,
    input  logic [widthad-1:0]   address_a,
    input  logic [width/8-1:0]   byteena_a,
    input  logic [width-1:0]     data_a,
    input  logic                 wren_a,
    input  logic [widthad-1:0]   address_b,
    input  logic                 rden_b,
    output logic [width-1:0]     q_b,
    output logic                 q_valid_b,
    input  logic                 clear_req,
    output logic                 busy
);

    localparam int nbytes = width / 8;
    localparam logic [widthad:0]   num_lim  = (widthad + 1)'(numwords);
    localparam logic [widthad-1:0] last_idx = widthad'(numwords - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t             state, state_nxt;
    logic [widthad-1:0] cnt, cnt_nxt;
    logic               boot, boot_nxt;
    logic               start_clear;
    logic               wr_en;
    logic               rd_acc;
    logic [widthad-1:0] rd_idx;

    logic [width-1:0]   mem [numwords];

    logic [width-1:0]   ram_q;
    logic [nbytes-1:0]  col_be;
    logic [width-1:0]   col_dat;
    logic               v1;
    logic [width-1:0]   merged;

    assign busy        = (state == CLEAR);
    // boot requests one sweep on the first edge after reset when auto-clear is enabled
    assign start_clear = (state == IDLE) && (clear_req || boot);
    assign wr_en       = wren_a && !busy && !start_clear && ({1'b0, address_a} < num_lim);
    assign rd_acc      = rden_b && !busy;
    assign rd_idx      = ({1'b0, address_b} < num_lim) ? address_b : '0;

    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
            state <= IDLE;
            cnt   <= '0;
            boot  <= (clear_on_reset != 0);
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            boot  <= boot_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        boot_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (start_clear) begin
                    state_nxt = CLEAR;
                    cnt_nxt   = '0;
                end
            end
            CLEAR: begin
                cnt_nxt = cnt + 1'b1;
                if (cnt == last_idx) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock_in) begin
        if (busy) begin
            mem[cnt] <= '0;
        end else if (wr_en) begin
            for (int b = 0; b < nbytes; b++) begin
                if (byteena_a[b]) mem[address_a][8*b +: 8] <= data_a[8*b +: 8];
            end
        end
    end

    // Read-before-write capture plus the registered collision compare, aligned with ram_q
    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
            ram_q   <= '0;
            col_be  <= '0;
            col_dat <= '0;
            v1      <= 1'b0;
        end else begin
            v1 <= rd_acc;
            if (rd_acc) begin
                ram_q   <= mem[rd_idx];
                col_be  <= ((bypass != 0) && wr_en && (address_a == address_b)) ? byteena_a : '0;
                col_dat <= data_a;
            end
        end
    end

    always_comb begin
        merged = ram_q;
        for (int b = 0; b < nbytes; b++) begin
            if (col_be[b]) merged[8*b +: 8] = col_dat[8*b +: 8];
        end
    end

    if (read_latency <= 1) begin : g_lat1
        assign q_b       = merged;
        assign q_valid_b = v1;
    end else begin : g_pipe
        localparam int stages = read_latency - 1;

        logic [width-1:0]  stg_dat [stages];
        logic [stages-1:0] stg_vld;

        // Each stage only loads on a valid beat so the output holds between beats
        always_ff @(posedge clock_in or negedge reset_in) begin
            if (!reset_in) begin
                for (int i = 0; i < stages; i++) stg_dat[i] <= '0;
                stg_vld <= '0;
            end else begin
                stg_vld[0] <= v1;
                if (v1) stg_dat[0] <= merged;
                for (int i = 1; i < stages; i++) begin
                    stg_vld[i] <= stg_vld[i-1];
                    if (stg_vld[i-1]) stg_dat[i] <= stg_dat[i-1];
                end
            end
        end

        assign q_b       = stg_dat[stages-1];
        assign q_valid_b = stg_vld[stages-1];
    end

endmodule

// File: tb/tb_dpram_be_pipe.sv
// Directed bench: dut_a (latency 3, bypass), dut_b (latency 1, no bypass) share stimulus;
// dut_c (auto-clear on reset) has its own reset and is only observed for busy.
module tb_dpram_be_pipe;

    localparam int NW = 16;
    localparam int AW = 8;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n, rst_c;
    logic [AW-1:0] address_a, address_b;
    logic [3:0]    byteena_a;
    logic [DW-1:0] data_a;
    logic          wren_a, rden_b, clear_req;
    logic [DW-1:0] qa, qb, qc;
    logic          va, vb, vc, busya, busyb, busyc;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    dpram_be_pipe #(.numwords(NW), .widthad(AW), .width(DW), .read_latency(3), .bypass(1), .clear_on_reset(0)) dut_a (
        .clock_in(clk), .reset_in(rst_n), .address_a(address_a), .byteena_a(byteena_a), .data_a(data_a),
        .wren_a(wren_a), .address_b(address_b), .rden_b(rden_b), .q_b(qa), .q_valid_b(va),
        .clear_req(clear_req), .busy(busya));

    dpram_be_pipe #(.numwords(NW), .widthad(AW), .width(DW), .read_latency(1), .bypass(0), .clear_on_reset(0)) dut_b (
        .clock_in(clk), .reset_in(rst_n), .address_a(address_a), .byteena_a(byteena_a), .data_a(data_a),
        .wren_a(wren_a), .address_b(address_b), .rden_b(rden_b), .q_b(qb), .q_valid_b(vb),
        .clear_req(clear_req), .busy(busyb));

    dpram_be_pipe #(.numwords(NW), .widthad(AW), .width(DW), .read_latency(2), .bypass(1), .clear_on_reset(1)) dut_c (
        .clock_in(clk), .reset_in(rst_c), .address_a(address_a), .byteena_a(byteena_a), .data_a(data_a),
        .wren_a(wren_a), .address_b(address_b), .rden_b(rden_b), .q_b(qc), .q_valid_b(vc),
        .clear_req(clear_req), .busy(busyc));

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wren_a    = 1'b0;
        rden_b    = 1'b0;
        clear_req = 1'b0;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] be);
        address_a = a;
        data_a    = d;
        byteena_a = be;
        wren_a    = 1'b1;
        cyc();
        wren_a    = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rst_c = 1'b0;
        idle();
        address_a = '0;
        address_b = '0;
        byteena_a = '0;
        data_a    = '0;
        #12;
        checks++; if ({qa, va, busya} !== 34'h0) $display("FAIL reset_a: got q=%h v=%b busy=%b want 0", qa, va, busya); else passed++;
        checks++; if ({qb, vb, busyb} !== 34'h0) $display("FAIL reset_b: got q=%h v=%b busy=%b want 0", qb, vb, busyb); else passed++;
        checks++; if ({qc, vc, busyc} !== 34'h0) $display("FAIL reset_c: got q=%h v=%b busy=%b want 0", qc, vc, busyc); else passed++;
        rst_n = 1'b1;
    endtask

    task automatic test_byte_enable();
        wr(8'd5, 32'hAABBCCDD, 4'b1111);
        wr(8'd5, 32'h11223344, 4'b0101);
        rden_b = 1'b1; address_b = 8'd5;
        cyc();
        rden_b = 1'b0;
        checks++; if ({vb, qb} !== {1'b1, 32'hAA22CC44}) $display("FAIL be_lat1_beat: got v=%b q=%h want 1/aa22cc44", vb, qb); else passed++;
        checks++; if (va !== 1'b0) $display("FAIL be_lat3_early0: got v=%b want 0", va); else passed++;
        cyc();
        checks++; if ({vb, qb} !== {1'b0, 32'hAA22CC44}) $display("FAIL be_lat1_hold: got v=%b q=%h want 0/aa22cc44", vb, qb); else passed++;
        checks++; if (va !== 1'b0) $display("FAIL be_lat3_early1: got v=%b want 0", va); else passed++;
        cyc();
        checks++; if ({va, qa} !== {1'b1, 32'hAA22CC44}) $display("FAIL be_lat3_beat: got v=%b q=%h want 1/aa22cc44", va, qa); else passed++;
        cyc();
        checks++; if ({va, qa} !== {1'b0, 32'hAA22CC44}) $display("FAIL be_lat3_hold: got v=%b q=%h want 0/aa22cc44", va, qa); else passed++;
    endtask

    task automatic test_streaming();
        logic [32:0] exp_a, exp_b;
        for (int i = 0; i < 8; i++) wr(i[AW-1:0], 32'h100 + 32'(i), 4'b1111);
        for (int c = 0; c < 11; c++) begin
            rden_b    = (c < 8);
            address_b = c[AW-1:0];
            cyc();
            exp_b = (c < 8) ? {1'b1, 32'h100 + 32'(c)} : {1'b0, 32'h107};
            if (c < 2)       exp_a = {1'b0, 32'hAA22CC44};
            else if (c < 10) exp_a = {1'b1, 32'h100 + 32'(c - 2)};
            else             exp_a = {1'b0, 32'h107};
            checks++; if ({vb, qb} !== exp_b) $display("FAIL stream_b[%0d]: got v=%b q=%h want %h", c, vb, qb, exp_b); else passed++;
            checks++; if ({va, qa} !== exp_a) $display("FAIL stream_a[%0d]: got v=%b q=%h want %h", c, va, qa, exp_a); else passed++;
        end
        rden_b = 1'b0;
    endtask

    task automatic test_collision();
        wr(8'd3, 32'h0, 4'b1111);
        address_a = 8'd3; data_a = 32'hFFFFFFFF; byteena_a = 4'b0011; wren_a = 1'b1;
        address_b = 8'd3; rden_b = 1'b1;
        cyc();
        idle();
        checks++; if ({vb, qb} !== {1'b1, 32'h0}) $display("FAIL coll_nobypass: got v=%b q=%h want 1/00000000", vb, qb); else passed++;
        cyc();
        cyc();
        checks++; if ({va, qa} !== {1'b1, 32'h0000FFFF}) $display("FAIL coll_bypass: got v=%b q=%h want 1/0000ffff", va, qa); else passed++;
        // follow-up read, then a later write to the same word while it is in flight
        rden_b = 1'b1; address_b = 8'd3;
        cyc();
        rden_b = 1'b0;
        checks++; if ({vb, qb} !== {1'b1, 32'h0000FFFF}) $display("FAIL coll_after_b: got v=%b q=%h want 1/0000ffff", vb, qb); else passed++;
        wr(8'd3, 32'hFFFFFFFF, 4'b1111);
        cyc();
        checks++; if ({va, qa} !== {1'b1, 32'h0000FFFF}) $display("FAIL coll_inflight_a: got v=%b q=%h want 1/0000ffff", va, qa); else passed++;
        // out-of-range write must not alias onto word 4
        wr(8'd20, 32'h5A5A5A5A, 4'b1111);
        rden_b = 1'b1; address_b = 8'd20;
        cyc();
        checks++; if (vb !== 1'b1) $display("FAIL oor_valid_b: got v=%b want 1", vb); else passed++;
        address_b = 8'd4;
        cyc();
        rden_b = 1'b0;
        checks++; if ({vb, qb} !== {1'b1, 32'h104}) $display("FAIL oor_alias_b: got v=%b q=%h want 1/00000104", vb, qb); else passed++;
        cyc();
        checks++; if (va !== 1'b1) $display("FAIL oor_valid_a: got v=%b want 1", va); else passed++;
        cyc();
        checks++; if ({va, qa} !== {1'b1, 32'h104}) $display("FAIL oor_alias_a: got v=%b q=%h want 1/00000104", va, qa); else passed++;
    endtask

    task automatic test_clear();
        int nb;
        int stray;
        nb = 0;
        stray = 0;
        for (int i = 0; i < NW; i++) wr(i[AW-1:0], 32'hDEADBEEF, 4'b1111);
        clear_req = 1'b1; rden_b = 1'b1; address_b = 8'd2;
        cyc();
        clear_req = 1'b0; rden_b = 1'b0;
        for (int i = 0; i < 40 && busya; i++) begin
            nb++;
            if (nb == 1) begin
                checks++; if ({vb, qb} !== {1'b1, 32'hDEADBEEF}) $display("FAIL clr_preread_b: got v=%b q=%h want 1/deadbeef", vb, qb); else passed++;
            end else if (vb) stray++;
            if (nb == 3) begin
                checks++; if ({va, qa} !== {1'b1, 32'hDEADBEEF}) $display("FAIL clr_preread_a: got v=%b q=%h want 1/deadbeef", va, qa); else passed++;
            end else if (va) stray++;
            address_a = 8'd0; data_a = 32'hAAAAAAAA; byteena_a = 4'b1111; wren_a = 1'b1;
            address_b = 8'd0; rden_b = 1'b1;
            clear_req = (nb == 5);
            cyc();
        end
        idle();
        checks++; if (nb !== NW) $display("FAIL clr_busy_len: got %0d cycles want %0d", nb, NW); else passed++;
        cyc();
        if (va || vb) stray++;
        cyc();
        if (va || vb) stray++;
        checks++; if (stray !== 0) $display("FAIL clr_dropped_reads: got %0d stray beats want 0", stray); else passed++;
        for (int c = 0; c < NW + 2; c++) begin
            rden_b    = (c < NW);
            address_b = c[AW-1:0];
            cyc();
            if (c < NW) begin
                checks++; if ({vb, qb} !== {1'b1, 32'h0}) $display("FAIL clr_read_b[%0d]: got v=%b q=%h want 1/00000000", c, vb, qb); else passed++;
            end
            if (c >= 2) begin
                checks++; if ({va, qa} !== {1'b1, 32'h0}) $display("FAIL clr_read_a[%0d]: got v=%b q=%h want 1/00000000", c - 2, va, qa); else passed++;
            end
        end
        rden_b = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [31:0] exp;
        for (int i = 0; i < NW; i++) wr(i[AW-1:0], 32'hDEADBEEF, 4'b1111);
        rden_b = 1'b1; address_b = 8'd7;
        cyc();
        cyc();
        clear_req = 1'b1;
        cyc();
        idle();
        for (int i = 0; i < 6; i++) cyc();
        checks++; if ({va, qa, busya} !== {1'b0, 32'hDEADBEEF, 1'b1}) $display("FAIL rmid_pre: got v=%b q=%h busy=%b want 0/deadbeef/1", va, qa, busya); else passed++;
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({qa, va, busya} !== 34'h0) $display("FAIL rmid_async_a: got q=%h v=%b busy=%b want 0", qa, va, busya); else passed++;
        checks++; if ({qb, vb, busyb} !== 34'h0) $display("FAIL rmid_async_b: got q=%h v=%b busy=%b want 0", qb, vb, busyb); else passed++;
        #1 rst_n = 1'b1;
        for (int c = 0; c < NW; c++) begin
            rden_b    = 1'b1;
            address_b = c[AW-1:0];
            cyc();
            exp = (c < 6) ? 32'h0 : 32'hDEADBEEF;
            checks++; if ({vb, qb} !== {1'b1, exp}) $display("FAIL rmid_word[%0d]: got v=%b q=%h want 1/%h", c, vb, qb, exp); else passed++;
        end
        rden_b = 1'b0;
        cyc();
        cyc();
    endtask

    task automatic test_clear_on_reset();
        int nb;
        nb = 0;
        idle();
        checks++; if (busyc !== 1'b0) $display("FAIL cor_in_reset: got busy=%b want 0", busyc); else passed++;
        #3 rst_c = 1'b1;
        cyc();
        checks++; if (busyc !== 1'b1) $display("FAIL cor_first_cycle: got busy=%b want 1", busyc); else passed++;
        for (int i = 0; i < 40 && busyc; i++) begin
            nb++;
            cyc();
        end
        checks++; if (nb !== NW) $display("FAIL cor_busy_len: got %0d cycles want %0d", nb, NW); else passed++;
        // reset mid-sweep, then the sweep restarts in full
        #3 rst_c = 1'b0;
        #1 rst_c = 1'b1;
        cyc();
        for (int i = 0; i < 6; i++) cyc();
        #2 rst_c = 1'b0;
        #1;
        checks++; if (busyc !== 1'b0) $display("FAIL cor_abort: got busy=%b want 0", busyc); else passed++;
        #1 rst_c = 1'b1;
        nb = 0;
        cyc();
        for (int i = 0; i < 40 && busyc; i++) begin
            nb++;
            cyc();
        end
        checks++; if (nb !== NW) $display("FAIL cor_restart_len: got %0d cycles want %0d", nb, NW); else passed++;
    endtask

    initial begin
        test_reset();
        test_byte_enable();
        test_streaming();
        test_collision();
        test_clear();
        test_reset_mid();
        test_clear_on_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
